dual_lane_scheduler: RTL and testbench
======================================

# dual_lane_scheduler

Round-robin scheduler that shares one two-lane capture register pair (`out1`/`out2`) among `NREQ` requesters. Accepted words fill lane 1 then lane 2 alternately, mirroring the high-phase/low-phase capture pairing used elsewhere in the design. Requesters use a valid/ready handshake. A partially filled pair is abandoned after a programmable idle timeout.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8
- `WIDTH`, 4: data word width
- `IDLE_TMO`, 8: idle cycles allowed in HI before the pair is aborted, legal range 1..255
- `clk` input 1: clock; all state updates on the rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `req_valid` input NREQ: per-requester valid
- `req_data` input NREQ*WIDTH: requester i drives bits [i*WIDTH +: WIDTH]
- `req_ready` output NREQ: one-hot grant, combinational
- `out_ready` input 1: downstream accepts a write this cycle
- `out1` output WIDTH: lane 1 data register
- `out2` output WIDTH: lane 2 data register
- `out1_vld` output 1: one-cycle pulse, `out1` updated
- `out2_vld` output 1: one-cycle pulse, `out2` updated
- `pair_done` output 1: one-cycle pulse, coincident with `out2_vld`
- `pair_abort` output 1: one-cycle pulse, half-filled pair dropped

## Operation
- **State machine**, reset state IDLE:
  - IDLE: no pair open; next transfer goes to lane 1.
  - HI: lane 1 filled; next transfer goes to lane 2.
  - LO: pair completed; next transfer goes to lane 1.
- **Arbitration**, evaluated every cycle with `out_ready`=1 and any `req_valid`=1:
  - Winner w is the first asserted requester scanning cyclically from `rr_ptr`.
  - `req_ready[w]`=1 and all other bits 0.
  - With `out_ready`=0, `req_ready` is all 0.
- **Transfer** occurs when `req_valid[w]` & `req_ready[w]` at a clock edge:
  - `rr_ptr` <= (w+1) mod NREQ.
  - From IDLE or LO: `out1` <= data, `out1_vld` pulses, state -> HI.
  - From HI: `out2` <= data, `out2_vld` and `pair_done` pulse, state -> LO.
- **LO with no transfer:** state -> IDLE on the next edge. Outputs hold.
- **Idle counter (8-bit):**
  - Cleared on every transfer and on entering HI.
  - Increments in HI only on cycles with `out_ready`=1 and no transfer.
  - Frozen while `out_ready`=0 (stalls never abort a pair).
  - When it reaches `IDLE_TMO`: `pair_abort` pulses, state -> IDLE, counter clears, `out1` keeps its value.
- **Simultaneous events:** a transfer in the same cycle the counter would reach `IDLE_TMO` wins. It fills lane 2 and no abort occurs.
- **Reset**, asynchronous and valid at any point including mid-pair:
  - `out1`, `out2` = 0.
  - All pulses = 0.
  - `rr_ptr` = 0, counter = 0, state = IDLE.
  - `req_ready` = 0 while `rst_n` is low.

## Timing
- `req_ready` is combinational from `req_valid`, `out_ready`, `rr_ptr` and state. There is no combinational path from `req_data` to any output.
- Latency: a transfer at edge E produces registered outputs visible in the cycle after E (1 cycle).
- Throughput: one transfer per cycle; one full pair every 2 cycles.
- `rr_ptr` width is $clog2(NREQ). Wrap-around from NREQ-1 goes to 0.
- All `*_vld`, `pair_done` and `pair_abort` pulses are exactly one cycle and registered.

## Configuration
- Macro `DUAL_LANE_SCHED_STATS_EN`:
  - Defined: adds output `grant_cnt` [15:0], which counts transfers and saturates at 16'hFFFF.
  - Defined: adds output `abort_cnt` [7:0], which counts `pair_abort` and saturates at 8'hFF.
  - Both counters reset to 0.
  - Undefined: both ports and their logic are absent, and behaviour is otherwise identical.

## Test plan
- **Reset mid-pair:** after a transfer into HI, pulse `rst_n` low asynchronously between edges -> `out1`=`out2`=0, all pulses 0, `req_ready`=0. The next transfer lands in lane 1.
- **Single requester:** requester 0 sends 3 then 5 back-to-back, `out_ready`=1 -> `out1`=3 with `out1_vld`, then `out2`=5 with `out2_vld`+`pair_done` one cycle later.
- **Round-robin:** all four valid, data 1,2,3,4 held -> grant order 0,1,2,3,0. Output sequence is `out1`=1, `out2`=2, `out1`=3, `out2`=4, `out1`=1.
- **Timeout:** one transfer of 12, then no requests for 8 cycles with `IDLE_TMO`=8 -> `pair_abort` on the 8th idle cycle. The next transfer of 13 lands in `out1`. A request arriving on the 8th idle cycle instead lands in `out2` with no abort.
- **Stall:** state HI with `out_ready`=0 for 20 cycles and all requests valid -> `req_ready`=0, outputs hold, no `pair_abort`. Releasing `out_ready` fills lane 2 next edge.
- **Stats (macro defined):** 300 transfers plus 2 aborts -> `grant_cnt`=300, `abort_cnt`=2. Forcing 70000 transfers -> `grant_cnt`=16'hFFFF.

Source files
------------

// File: rtl/dual_lane_scheduler_if.sv
// Bus bundle for dual_lane_scheduler: requester valid/ready/data on one side,
// the two-lane capture register pair and its status pulses on the other.
// The master modport is the requester/downstream environment, the slave
// modport is the scheduler itself.
interface dual_lane_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_ready;
  logic [WIDTH-1:0]      out1;
  logic [WIDTH-1:0]      out2;
  logic                  out1_vld;
  logic                  out2_vld;
  logic                  pair_done;
  logic                  pair_abort;

  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out1,
    input  out2,
    input  out1_vld,
    input  out2_vld,
    input  pair_done,
    input  pair_abort
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out1,
    output out2,
    output out1_vld,
    output out2_vld,
    output pair_done,
    output pair_abort
  );
endinterface

// File: rtl/dual_lane_scheduler.sv
// dual_lane_scheduler
// Round-robin scheduler sharing one two-lane capture register pair among
// NREQ requesters. Accepted words fill lane 1 then lane 2; a half-filled
// pair is dropped after IDLE_TMO idle (non-stalled) cycles.
// Optional statistics counters are compiled in with the macro
// DUAL_LANE_SCHED_STATS_EN (adds grant_cnt and abort_cnt outputs).
module dual_lane_scheduler #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 4,
  parameter int IDLE_TMO = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  dual_lane_scheduler_if.slave       bus
`ifdef DUAL_LANE_SCHED_STATS_EN
  ,
  output logic [15:0]                grant_cnt,
  output logic [7:0]                 abort_cnt
`endif
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] TMO = 8'(IDLE_TMO);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [7:0]        idle_cnt;

  logic [NREQ-1:0]   grant;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  int                cand;
  logic [WIDTH-1:0]  win_data;
  logic              transfer;
  logic              abort;
  logic              to_lane2;

  // Cyclic priority scan starting at rr_ptr; grants nothing while the
  // downstream is stalled or the block is held in reset.
  always_comb begin
    grant     = '0;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    if (rst_n && bus.out_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (int'(rr_ptr) + k) % NREQ;
        if (!win_found && bus.req_valid[cand]) begin
          win_found   = 1'b1;
          win_idx     = PTR_W'(cand);
          grant[cand] = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign transfer      = win_found;
  assign win_data      = bus.req_data[int'(win_idx)*WIDTH +: WIDTH];
  assign to_lane2      = (state == HI);

  // A pending abort loses to a transfer in the same cycle; stalled cycles
  // never advance toward the timeout.
  assign abort = (state == HI) && bus.out_ready && !transfer &&
                 ((idle_cnt + 8'd1) == TMO);

  // Next-state selection for the lane-pairing state machine.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (transfer) state_nxt = HI;
      end
      HI: begin
        if (transfer)   state_nxt = LO;
        else if (abort) state_nxt = IDLE;
      end
      LO: begin
        if (transfer) state_nxt = HI;
        else          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Round-robin pointer moves one past the winner on every transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      if (win_idx == LAST_IDX) rr_ptr <= '0;
      else                     rr_ptr <= win_idx + PTR_W'(1);
    end
  end

  // Idle counter only runs in HI on non-stalled, transfer-free cycles and
  // is cleared whenever the pair opens, completes or is aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= 8'd0;
    end else if (transfer || state != HI || abort) begin
      idle_cnt <= 8'd0;
    end else if (bus.out_ready) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  // Lane data registers: lane 1 on a transfer outside HI, lane 2 inside HI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out1 <= '0;
      bus.out2 <= '0;
    end else if (transfer) begin
      if (to_lane2) bus.out2 <= win_data;
      else          bus.out1 <= win_data;
    end
  end

  // Registered single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out1_vld   <= 1'b0;
      bus.out2_vld   <= 1'b0;
      bus.pair_done  <= 1'b0;
      bus.pair_abort <= 1'b0;
    end else begin
      bus.out1_vld   <= transfer && !to_lane2;
      bus.out2_vld   <= transfer && to_lane2;
      bus.pair_done  <= transfer && to_lane2;
      bus.pair_abort <= abort;
    end
  end

`ifdef DUAL_LANE_SCHED_STATS_EN
  // Saturating counts of transfers and aborted pairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= 16'd0;
      abort_cnt <= 8'd0;
    end else begin
      if (transfer && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
      if (abort && abort_cnt != 8'hFF)       abort_cnt <= abort_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_lane_scheduler.sv
// Scoreboard bench for dual_lane_scheduler (NREQ=4, WIDTH=4, IDLE_TMO=8).
// Stimulus pushes the expected lane event into a queue; a negedge monitor
// pops and compares whenever the DUT raises out1_vld, out2_vld or pair_abort.
module tb_dual_lane_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  localparam int K_L1 = 1;
  localparam int K_L2 = 2;
  localparam int K_AB = 3;

  typedef struct {
    int kind;
    int data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  dual_lane_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef DUAL_LANE_SCHED_STATS_EN
  logic [15:0] grant_cnt;
  logic [7:0]  abort_cnt;
`endif

  dual_lane_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDLE_TMO(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DUAL_LANE_SCHED_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .abort_cnt (abort_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_exp(input int kind, input int data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string name, input int kind, input int data);
    exp_t e;
    if (sb.size() == 0) begin
      check_output({name, "_unexpected"}, kind, 0);
    end else begin
      e = sb.pop_front();
      check_output({name, "_kind"}, kind, e.kind);
      check_output({name, "_data"}, data, e.data);
    end
  endtask

  // Monitor: sample away from the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out1_vld) pop_check("lane1", K_L1, int'(bus.out1));
      if (bus.out2_vld) begin
        pop_check("lane2", K_L2, int'(bus.out2));
        check_output("pair_done_with_out2", int'(bus.pair_done), 1);
      end else if (bus.pair_done) begin
        check_output("pair_done_alone", 1, 0);
      end
      if (bus.pair_abort) pop_check("abort", K_AB, int'(bus.out1));
    end
  end

  // Drive one cycle of inputs, check the combinational grant, then clock it.
  task automatic apply_stimulus(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] d,
                                input logic ordy, input logic [NREQ-1:0] exp_rdy);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.out_ready = ordy;
    #1;
    check_output("req_ready", int'(bus.req_ready), int'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset pulse placed between clock edges, with reset-state checks.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.out_ready = 1'b1;
    #1;
    check_output("rst_out1", int'(bus.out1), 0);
    check_output("rst_out2", int'(bus.out2), 0);
    check_output("rst_pulses", int'({bus.out1_vld, bus.out2_vld, bus.pair_done, bus.pair_abort}), 0);
    check_output("rst_req_ready", int'(bus.req_ready), 0);
`ifdef DUAL_LANE_SCHED_STATS_EN
    check_output("rst_grant_cnt", int'(grant_cnt), 0);
    check_output("rst_abort_cnt", int'(abort_cnt), 0);
`endif
    bus.req_valid = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Bound on total run time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;

    // Reset mid-pair, then the next word must land in lane 1.
    do_reset();
    push_exp(K_L1, 7);
    apply_stimulus(4'b0001, 16'h0007, 1'b1, 4'b0001);
    idle_cycles(1);
    do_reset();
    push_exp(K_L1, 6);
    apply_stimulus(4'b0001, 16'h0006, 1'b1, 4'b0001);
    idle_cycles(2);

    // Single requester, back-to-back pair 3 then 5.
    do_reset();
    push_exp(K_L1, 3);
    apply_stimulus(4'b0001, 16'h0003, 1'b1, 4'b0001);
    push_exp(K_L2, 5);
    apply_stimulus(4'b0001, 16'h0005, 1'b1, 4'b0001);
    idle_cycles(3);

    // Round-robin over four requesters with data 1..4; the fifth word opens
    // a pair that later times out with out1 still holding 1.
    do_reset();
    push_exp(K_L1, 1);
    apply_stimulus(4'b1111, 16'h4321, 1'b1, 4'b0001);
    push_exp(K_L2, 2);
    apply_stimulus(4'b1111, 16'h4321, 1'b1, 4'b0010);
    push_exp(K_L1, 3);
    apply_stimulus(4'b1111, 16'h4321, 1'b1, 4'b0100);
    push_exp(K_L2, 4);
    apply_stimulus(4'b1111, 16'h4321, 1'b1, 4'b1000);
    push_exp(K_L1, 1);
    apply_stimulus(4'b1111, 16'h4321, 1'b1, 4'b0001);
    push_exp(K_AB, 1);
    idle_cycles(10);

    // Timeout after 8 idle cycles, next word restarts in lane 1.
    do_reset();
    push_exp(K_L1, 12);
    apply_stimulus(4'b0001, 16'h000C, 1'b1, 4'b0001);
    push_exp(K_AB, 12);
    idle_cycles(8);
    push_exp(K_L1, 13);
    apply_stimulus(4'b0001, 16'h000D, 1'b1, 4'b0001);
    push_exp(K_AB, 13);
    idle_cycles(10);

    // Transfer on the 8th idle cycle beats the timeout.
    do_reset();
    push_exp(K_L1, 12);
    apply_stimulus(4'b0001, 16'h000C, 1'b1, 4'b0001);
    idle_cycles(7);
    push_exp(K_L2, 7);
    apply_stimulus(4'b0001, 16'h0007, 1'b1, 4'b0001);
    idle_cycles(10);

    // Stall in HI for 20 cycles: no grants, no abort, outputs hold.
    do_reset();
    push_exp(K_L1, 9);
    apply_stimulus(4'b0001, 16'hCBA9, 1'b1, 4'b0001);
    for (int i = 0; i < 20; i++) apply_stimulus(4'b1111, 16'hCBA9, 1'b0, 4'b0000);
    check_output("stall_out1", int'(bus.out1), 9);
    push_exp(K_L2, 10);
    apply_stimulus(4'b1111, 16'hCBA9, 1'b1, 4'b0010);
    idle_cycles(3);

`ifdef DUAL_LANE_SCHED_STATS_EN
    // 300 transfers in total and 2 aborted pairs.
    do_reset();
    for (int i = 0; i < 298; i++) begin
      push_exp((i % 2 == 0) ? K_L1 : K_L2, 5);
      apply_stimulus(4'b0001, 16'h0005, 1'b1, 4'b0001);
    end
    idle_cycles(2);
    for (int j = 0; j < 2; j++) begin
      push_exp(K_L1, 5);
      apply_stimulus(4'b0001, 16'h0005, 1'b1, 4'b0001);
      push_exp(K_AB, 5);
      idle_cycles(10);
    end
    check_output("grant_cnt", int'(grant_cnt), 300);
    check_output("abort_cnt", int'(abort_cnt), 2);
`endif

    idle_cycles(2);
    check_output("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
